// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: glyph codes,
// formatter FSM states and the displayable magnitude limits.
package calc_pkg;

  localparam logic [5:0] GLY_BLANK = 6'd36;
  localparam logic [5:0] GLY_MINUS = 6'd37;
  localparam logic [5:0] GLY_E     = 6'd14;
  localparam logic [5:0] GLY_R     = 6'd27;

  localparam int unsigned MAX_POS = 999999;
  localparam int unsigned MAX_NEG = 99999;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FORMAT
  } state_t;

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: every BCD nibble of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_stage (
  input  logic [23:0] i_bcd,
  output logic [23:0] o_bcd
);

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_nib
      logic [3:0] w_nib;
      assign w_nib = i_bcd[gi*4 +: 4];
      assign o_bcd[gi*4 +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end
  endgenerate

endmodule

// File: rtl/bcd_display_formatter.sv
// Sequential binary-to-glyph formatter: iterative double dabble followed by
// leading-zero blanking, minus placement and the "Err" pattern.
module bcd_display_formatter
  import calc_pkg::*;
#(
  parameter int DATA_W   = 20,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [39:0] i_value,
  input  logic        i_sign,
  input  logic        i_err,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf,
  output logic [5:0]  digit_pos,
  output logic [5:0]  ten_pos,
  output logic [5:0]  hundred_pos,
  output logic [5:0]  thousand_pos,
  output logic [5:0]  ten_thousand_pos,
  output logic [5:0]  hundred_thousand_pos
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [39:0] LIM_POS = 40'(MAX_POS);
  localparam logic [39:0] LIM_NEG = 40'(MAX_NEG);

  state_t r_state;
  state_t w_state_next;

  logic [39:0]       r_value;
  logic              r_sign;
  logic              r_err;
  logic              r_fmt_err;
  logic              r_range_err;
  logic [23:0]       r_bcd;
  logic [DATA_W-1:0] r_bin;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic [5:0]        r_glyph [6];

  logic        w_range_err;
  logic        w_last;
  logic [23:0] w_bcd_adj;
  logic [3:0]  w_nib [6];
  logic [2:0]  w_msd;
  logic        w_nonzero;
  logic [5:0]  w_glyph [6];

  assign w_range_err = (r_value > LIM_POS) || (r_sign && (r_value > LIM_NEG));
  assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));

  bcd_add3_stage u_add3 (
    .i_bcd (r_bcd),
    .o_bcd (w_bcd_adj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    w_state_next = (r_err || w_range_err) ? FORMAT : SHIFT;
      SHIFT:   if (w_last) w_state_next = FORMAT;
      FORMAT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value     <= '0;
      r_sign      <= 1'b0;
      r_err       <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_range_err <= 1'b0;
      r_bcd       <= '0;
      r_bin       <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_glyph[0]  <= 6'd0;
      for (int i = 1; i < 6; i++) r_glyph[i] <= GLY_BLANK;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_value <= i_value;
            r_sign  <= i_sign;
            r_err   <= i_err;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_fmt_err   <= r_err | w_range_err;
          r_range_err <= w_range_err;
          r_bcd       <= '0;
          r_bin       <= r_value[DATA_W-1:0];
          r_cnt       <= '0;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
        end
        FORMAT: begin
          for (int i = 0; i < 6; i++) r_glyph[i] <= w_glyph[i];
          r_done <= 1'b1;
          r_ovf  <= r_range_err;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // w_msd is the highest nonzero digit (units when the magnitude is zero).
  always_comb begin
    for (int i = 0; i < 6; i++) w_nib[i] = r_bcd[i*4 +: 4];
    w_msd = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (w_nib[i] != 4'd0) w_msd = 3'(i);
    end
    w_nonzero = (r_bcd != 24'd0);
    for (int i = 0; i < 6; i++) begin
      if (BLANK_LZ && (i > int'(w_msd))) begin
        w_glyph[i] = GLY_BLANK;
      end else begin
        w_glyph[i] = {2'b00, w_nib[i]};
      end
      if (r_sign && w_nonzero) begin
        if (BLANK_LZ) begin
          if (i == int'(w_msd) + 1) w_glyph[i] = GLY_MINUS;
        end else if (i == 5) begin
          w_glyph[i] = GLY_MINUS;
        end
      end
    end
    if (r_fmt_err) begin
      w_glyph[5] = GLY_E;
      w_glyph[4] = GLY_R;
      w_glyph[3] = GLY_R;
      w_glyph[2] = GLY_BLANK;
      w_glyph[1] = GLY_BLANK;
      w_glyph[0] = GLY_BLANK;
    end
  end

  assign o_busy               = r_busy;
  assign o_done               = r_done;
  assign o_ovf                = r_ovf;
  assign digit_pos            = r_glyph[0];
  assign ten_pos              = r_glyph[1];
  assign hundred_pos          = r_glyph[2];
  assign thousand_pos         = r_glyph[3];
  assign ten_thousand_pos     = r_glyph[4];
  assign hundred_thousand_pos = r_glyph[5];

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Bench for bcd_display_formatter: two instances (blanking on and off) share
// stimulus; a decimal-arithmetic model is compared against both every cycle.
module tb_bcd_display_formatter;

  localparam int DW = 20;
  localparam logic [5:0] B = 6'd36;
  localparam logic [5:0] M = 6'd37;
  localparam logic [5:0] E = 6'd14;
  localparam logic [5:0] R = 6'd27;
  localparam logic [35:0] ERR_PAT   = {E, R, R, B, B, B};
  localparam logic [35:0] RESET_PAT = {B, B, B, B, B, 6'd0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [39:0] i_value = '0;
  logic        i_sign = 1'b0;
  logic        i_err = 1'b0;

  logic        busy1, done1, ovf1, busy0, done0, ovf0;
  logic [5:0]  g1 [6];
  logic [5:0]  g0 [6];
  logic [35:0] pk1, pk0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign pk1 = {g1[5], g1[4], g1[3], g1[2], g1[1], g1[0]};
  assign pk0 = {g0[5], g0[4], g0[3], g0[2], g0[1], g0[0]};

  bcd_display_formatter #(.DATA_W(DW), .BLANK_LZ(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_value(i_value),
    .i_sign(i_sign), .i_err(i_err), .o_busy(busy1), .o_done(done1), .o_ovf(ovf1),
    .digit_pos(g1[0]), .ten_pos(g1[1]), .hundred_pos(g1[2]), .thousand_pos(g1[3]),
    .ten_thousand_pos(g1[4]), .hundred_thousand_pos(g1[5])
  );

  bcd_display_formatter #(.DATA_W(DW), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_value(i_value),
    .i_sign(i_sign), .i_err(i_err), .o_busy(busy0), .o_done(done0), .o_ovf(ovf0),
    .digit_pos(g0[0]), .ten_pos(g0[1]), .hundred_pos(g0[2]), .thousand_pos(g0[3]),
    .ten_thousand_pos(g0[4]), .hundred_thousand_pos(g0[5])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  function automatic bit range_bad(input logic [39:0] v, input bit s);
    longint unsigned mag;
    mag = 64'(v);
    return (mag > 999999) || (s && mag > 99999);
  endfunction

  // Displayed glyphs from the decimal value, most significant position first.
  function automatic logic [35:0] model(input logic [39:0] v, input bit s, input bit e, input bit blz);
    logic [5:0] g [6];
    longint unsigned mag;
    longint unsigned p;
    int nd;
    mag = 64'(v);
    if (e || range_bad(v, s)) return ERR_PAT;
    nd = 1;
    p  = 10;
    while (nd < 6 && mag >= p) begin
      nd++;
      p = p * 10;
    end
    p = 1;
    for (int i = 0; i < 6; i++) begin
      g[i] = 6'((mag / p) % 10);
      p = p * 10;
      if (blz && i >= nd) g[i] = B;
    end
    if (s && mag != 0) begin
      if (blz) g[nd] = M;
      else g[5] = M;
    end
    return {g[5], g[4], g[3], g[2], g[1], g[0]};
  endfunction

  // Per-cycle compare against the model; predicts the effect of the next edge.
  initial begin
    logic [35:0] eg1, eg0, pg1, pg0;
    logic eovf, povf, ebusy, edone;
    bit pend;
    int cnt;
    eg1 = RESET_PAT; eg0 = RESET_PAT; pg1 = '0; pg0 = '0;
    eovf = 0; povf = 0; ebusy = 0; edone = 0; pend = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        eg1 = RESET_PAT; eg0 = RESET_PAT;
        eovf = 0; ebusy = 0; edone = 0; pend = 0;
      end
      check("cycle_glyphs_blz1", 64'(pk1), 64'(eg1));
      check("cycle_glyphs_blz0", 64'(pk0), 64'(eg0));
      check("cycle_status", 64'({busy1, done1, ovf1, busy0, done0, ovf0}),
            64'({ebusy, edone, eovf, ebusy, edone, eovf}));
      if (rst_n) begin
        edone = 0;
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            eg1 = pg1; eg0 = pg0; eovf = povf;
            edone = 1; ebusy = 0; pend = 0;
          end
        end else if (i_start && !ebusy) begin
          pg1  = model(i_value, i_sign, i_err, 1'b1);
          pg0  = model(i_value, i_sign, i_err, 1'b0);
          povf = range_bad(i_value, i_sign);
          cnt  = (i_err || povf) ? 2 : DW + 2;
          pend = 1; ebusy = 1;
        end
      end
    end
  end

  task automatic run(input string nm, input logic [39:0] v, input bit s, input bit e,
                     input logic [35:0] x1, input logic [35:0] x0, input bit xovf,
                     input int xlat, input bit dup);
    int n;
    int extra;
    @(posedge clk); #2;
    i_value = v; i_sign = s; i_err = e; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_value = 40'($urandom);
    i_sign  = 1'($urandom_range(0, 1));
    i_err   = 1'($urandom_range(0, 1));
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done1) break;
      if (dup && n == 4) begin i_start = 1'b1; i_value = 40'd555; i_sign = 1'b0; i_err = 1'b0; end
      if (dup && n == 5) i_start = 1'b0;
    end
    check({nm, "_latency"}, 64'(n), 64'(xlat));
    check({nm, "_blz1"}, 64'(pk1), 64'(x1));
    check({nm, "_blz0"}, 64'(pk0), 64'(x0));
    check({nm, "_ovf"}, 64'({ovf1, ovf0}), 64'({xovf, xovf}));
    $display("txn %s value=%0d sign=%0d err=%0d latency=%0d glyphs=%0h", nm, v, s, e, n, pk1);
    if (dup) begin
      extra = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done1) extra++;
      end
      check({nm, "_single_done"}, 64'(extra), 64'd0);
      check({nm, "_held"}, 64'(pk1), 64'(x1));
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_glyphs", 64'(pk1), 64'(RESET_PAT));
    check("reset_status", 64'({busy1, done1, ovf1}), 64'd0);

    check("model_123456", 64'(model(40'd123456, 1'b0, 1'b0, 1'b1)),
          64'({6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}));
    check("model_neg42_blz1", 64'(model(40'd42, 1'b1, 1'b0, 1'b1)), 64'({B, B, B, M, 6'd4, 6'd2}));
    check("model_neg42_blz0", 64'(model(40'd42, 1'b1, 1'b0, 1'b0)), 64'({M, 6'd0, 6'd0, 6'd0, 6'd4, 6'd2}));
    check("model_neg0", 64'(model(40'd0, 1'b1, 1'b0, 1'b1)), 64'(RESET_PAT));

    // Reset in the middle of SHIFT.
    @(posedge clk); #2;
    i_value = 40'd123456; i_sign = 1'b0; i_err = 1'b0; i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("abort_glyphs", 64'(pk1), 64'(RESET_PAT));
    check("abort_busy", 64'({busy1, busy0}), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 || done0) n++;
    end
    check("abort_no_done", 64'(n), 64'd0);
    check("abort_held", 64'(pk0), 64'(RESET_PAT));
    $display("txn abort value=123456 reset mid-shift done_pulses=%0d", n);

    run("pos123456", 40'd123456, 1'b0, 1'b0, {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6},
        {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}, 1'b0, 22, 1'b0);
    run("neg42", 40'd42, 1'b1, 1'b0, {B, B, B, M, 6'd4, 6'd2},
        {M, 6'd0, 6'd0, 6'd0, 6'd4, 6'd2}, 1'b0, 22, 1'b0);
    run("ovf1000000", 40'd1000000, 1'b0, 1'b0, ERR_PAT, ERR_PAT, 1'b1, 2, 1'b0);
    run("neg100000", 40'd100000, 1'b1, 1'b0, ERR_PAT, ERR_PAT, 1'b1, 2, 1'b0);
    run("neg99999", 40'd99999, 1'b1, 1'b0, {M, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9},
        {M, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9}, 1'b0, 22, 1'b0);
    run("neg0", 40'd0, 1'b1, 1'b0, RESET_PAT, 36'd0, 1'b0, 22, 1'b0);
    run("dup7", 40'd7, 1'b0, 1'b0, {B, B, B, B, B, 6'd7},
        {6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd7}, 1'b0, 22, 1'b1);
    run("forced_err", 40'd5, 1'b0, 1'b1, ERR_PAT, ERR_PAT, 1'b0, 2, 1'b0);
    run("high_bits", 40'h10_0000_0005, 1'b0, 1'b0, ERR_PAT, ERR_PAT, 1'b1, 2, 1'b0);
    run("neg100", 40'd100, 1'b1, 1'b0, {B, B, M, 6'd1, 6'd0, 6'd0},
        {M, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0}, 1'b0, 22, 1'b0);
    run("pos999999", 40'd999999, 1'b0, 1'b0, {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9},
        {6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9}, 1'b0, 22, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
